// File: rtl/decoder_n_sync.sv
// -----------------------------------------------------------------------------
// decoder_n_sync
//
// This block registers a one-hot decode of a binary select. It has three
// operating states:
//   - idle:   outputs are cleared.
//   - decode: the decode of In is shown, either held as a level or as a
//             single-cycle pulse.
//   - scan:   one output bit is walked across all 2**N positions. Each
//             position is held for SCAN_DIV cycles, and the walk starts
//             at the value of In sampled on entry.
//
// Parameters
//   N         select width (1..6)
//   SCAN_DIV  scan dwell per output position, in cycles (>=1)
//   PULSE     decode style: 0 = level, 1 = one-cycle pulse on entry or on
//             a change of In
//
// Ports
//   clk     rising-edge clock for all state
//   rst     synchronous, active-high reset
//   enable  block enable; when low it overrides mode
//   mode    0 = decode, 1 = scan
//   In      select value (N bits)
//   Output  registered one-hot decode (2**N bits)
//   index   registered binary index of the asserted Output bit
//   valid   registered; high while Output carries a one-hot value
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | enable low; outputs cleared
// DECODE | enable high, mode low; Output follows In (level or pulse)
// SCAN   | enable high, mode high; walking one-hot, SCAN_DIV cycles/bit
// -----------------------------------------------------------------------------
module decoder_n_sync #(
  parameter int N        = 2,
  parameter int SCAN_DIV = 4,
  parameter bit PULSE    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic [N-1:0]      In,
  output logic [2**N-1:0]   Output,
  output logic [N-1:0]      index,
  output logic              valid
);

  localparam int              M          = 2**N;
  localparam int              DW         = $clog2(SCAN_DIV + 1);
  localparam logic [M-1:0]    ONE        = M'(1);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] dwell;
  logic [N-1:0]  scan_idx;
  logic [N-1:0]  in_q;

  logic          in_changed;
  logic          dwell_done;
  logic [N-1:0]  scan_next;

  // Change detection compares the live select against last cycle's copy.
  // That copy is refreshed in every state, so a select that changed while
  // the block was idle or scanning never produces a stale pulse later.
  assign in_changed = (In != in_q);
  assign dwell_done = (dwell == DWELL_LAST);
  // The N-bit add wraps naturally from 2**N-1 to 0.
  assign scan_next  = scan_idx + N'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      Output   <= '0;
      index    <= '0;
      valid    <= 1'b0;
      dwell    <= '0;
      scan_idx <= '0;
      in_q     <= '0;
    end else begin
      in_q <= In;

      if (!enable) begin
        // Disable wins over mode.
        state    <= IDLE;
        Output   <= '0;
        index    <= '0;
        valid    <= 1'b0;
        dwell    <= '0;
        scan_idx <= '0;
      end else if (!mode) begin
        state <= DECODE;
        dwell <= '0;
        if (!PULSE) begin
          Output <= ONE << In;
          index  <= In;
          valid  <= 1'b1;
        end else if (state != DECODE || in_changed) begin
          // Pulse on the first decode cycle, and on any change of In.
          Output <= ONE << In;
          index  <= In;
          valid  <= 1'b1;
        end else begin
          // Between pulses, index keeps the last decoded value.
          Output <= '0;
          valid  <= 1'b0;
        end
      end else begin
        state <= SCAN;
        if (state != SCAN) begin
          // The scan position is not kept across an exit; every entry
          // restarts the walk from In.
          scan_idx <= In;
          dwell    <= '0;
          Output   <= ONE << In;
          index    <= In;
          valid    <= 1'b1;
        end else if (dwell_done) begin
          scan_idx <= scan_next;
          dwell    <= '0;
          Output   <= ONE << scan_next;
          index    <= scan_next;
          valid    <= 1'b1;
        end else begin
          dwell    <= dwell + DW'(1);
          Output   <= ONE << scan_idx;
          index    <= scan_idx;
          valid    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_n_sync.sv
// -----------------------------------------------------------------------------
// tb_decoder_n_sync
//
// Directed bench with three instances of decoder_n_sync:
//   u0: N=2, SCAN_DIV=4, level decode
//   u1: N=2, SCAN_DIV=4, pulse decode
//   u2: N=3, SCAN_DIV=1, level decode
// All three share clk, rst, enable and mode. u0 and u1 share the 2-bit
// select; u2 has its own 3-bit select. Inputs change on the falling edge,
// and outputs are sampled on the next falling edge.
// -----------------------------------------------------------------------------
module tb_decoder_n_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       mode;
  logic [1:0] in2;
  logic [2:0] in3;

  logic [3:0] o0, o1;
  logic [1:0] x0, x1;
  logic       v0, v1;
  logic [7:0] o2;
  logic [2:0] x2;
  logic       v2;

  int n_checks = 0;
  int n_pass   = 0;
  bit inv_on   = 1'b0;

  always #5 clk = ~clk;

  decoder_n_sync #(.N(2), .SCAN_DIV(4), .PULSE(1'b0)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .In(in2),
    .Output(o0), .index(x0), .valid(v0));

  decoder_n_sync #(.N(2), .SCAN_DIV(4), .PULSE(1'b1)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .In(in2),
    .Output(o1), .index(x1), .valid(v1));

  decoder_n_sync #(.N(3), .SCAN_DIV(1), .PULSE(1'b0)) u2 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .In(in3),
    .Output(o2), .index(x2), .valid(v2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk0(input string tag, input int eo, input int ei, input int ev);
    chk({tag, "_u0_out"}, 32'(o0), eo);
    chk({tag, "_u0_idx"}, 32'(x0), ei);
    chk({tag, "_u0_vld"}, 32'(v0), ev);
  endtask

  task automatic chk1(input string tag, input int eo, input int ei, input int ev);
    chk({tag, "_u1_out"}, 32'(o1), eo);
    chk({tag, "_u1_idx"}, 32'(x1), ei);
    chk({tag, "_u1_vld"}, 32'(v1), ev);
  endtask

  task automatic chk2(input string tag, input int eo, input int ei, input int ev);
    chk({tag, "_u2_out"}, 32'(o2), eo);
    chk({tag, "_u2_idx"}, 32'(x2), ei);
    chk({tag, "_u2_vld"}, 32'(v2), ev);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Every cycle: Output is all-zero or one-hot, and it matches index when valid.
  always @(negedge clk) begin
    if (inv_on) begin
      chk("inv_u0_onehot", 32'($onehot0(o0)), 1);
      chk("inv_u0_match",  32'(!v0 || (o0 == (4'd1 << x0))), 1);
      chk("inv_u1_onehot", 32'($onehot0(o1)), 1);
      chk("inv_u1_match",  32'(!v1 || (o1 == (4'd1 << x1))), 1);
      chk("inv_u2_onehot", 32'($onehot0(o2)), 1);
      chk("inv_u2_match",  32'(!v2 || (o2 == (8'd1 << x2))), 1);
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 1'b0; in2 = 2'd0; in3 = 3'd0;
    tick();
    inv_on = 1'b1;
    tick();
    chk0("reset", 0, 0, 0);
    chk1("reset", 0, 0, 0);
    chk2("reset", 0, 0, 0);

    // Level decode sweep; pulse instance fires once per new value.
    rst = 1'b0; enable = 1'b1; mode = 1'b0;
    for (int v = 0; v < 4; v++) begin
      in2 = 2'(v);
      tick();
      chk0($sformatf("dec_v%0d_first", v), 1 << v, v, 1);
      chk1($sformatf("pls_v%0d_first", v), 1 << v, v, 1);
      for (int h = 0; h < 9; h++) begin
        tick();
        chk0($sformatf("dec_v%0d_hold%0d", v, h), 1 << v, v, 1);
        chk1($sformatf("pls_v%0d_hold%0d", v, h), 0, v, 0);
      end
    end

    // Pulse: In=10 held 5 cycles, then In=11.
    in2 = 2'd2;
    tick();
    chk1("pls_10_first", 4'b0100, 2, 1);
    for (int h = 0; h < 4; h++) begin
      tick();
      chk1($sformatf("pls_10_quiet%0d", h), 0, 2, 0);
    end
    in2 = 2'd3;
    tick();
    chk1("pls_11_first", 4'b1000, 3, 1);
    tick();
    chk1("pls_11_quiet", 0, 3, 0);

    // Scan entry from decode at In=10 (u2 at 110, dwell 1); In ignored afterwards.
    mode = 1'b1; in2 = 2'd2; in3 = 3'd6;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (k == 0) begin
        in2 = 2'd0;
        in3 = 3'd1;
      end
      chk0($sformatf("scan_k%0d", k), 1 << ((2 + k / 4) % 4), (2 + k / 4) % 4, 1);
      chk1($sformatf("scan_k%0d", k), 1 << ((2 + k / 4) % 4), (2 + k / 4) % 4, 1);
      chk2($sformatf("scan_k%0d", k), 1 << ((6 + k) % 8), (6 + k) % 8, 1);
    end

    // Drop enable mid-scan at index 11.
    enable = 1'b0;
    tick();
    chk0("scan_drop", 0, 0, 0);
    chk2("scan_drop", 0, 0, 0);

    // Re-enter scan at In=01; dwell restarts.
    enable = 1'b1; in2 = 2'd1; in3 = 3'd6;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk0($sformatf("rescan_k%0d", k), 1 << ((1 + k / 4) % 4), (1 + k / 4) % 4, 1);
      chk2($sformatf("rescan_k%0d", k), 1 << ((6 + k) % 8), (6 + k) % 8, 1);
    end

    // Simultaneous enable 1->0 and mode 0->1.
    mode = 1'b0; in2 = 2'd3;
    tick();
    chk0("pre_simul", 4'b1000, 3, 1);
    enable = 1'b0; mode = 1'b1;
    tick();
    chk0("simul", 0, 0, 0);

    // rst asserted mid-scan, then the first transition after release.
    enable = 1'b1; mode = 1'b1; in2 = 2'd1;
    tick();
    chk0("scan_b0", 4'b0010, 1, 1);
    tick();
    chk0("scan_b1", 4'b0010, 1, 1);
    rst = 1'b1;
    tick();
    chk0("rst_scan", 0, 0, 0);
    chk1("rst_scan", 0, 0, 0);
    chk2("rst_scan", 0, 0, 0);
    rst = 1'b0;
    tick();
    chk0("post_rst", 4'b0010, 1, 1);

    // Scan -> decode reflects the decode rule for the current In.
    mode = 1'b0; in2 = 2'd2;
    tick();
    chk0("scan2dec", 4'b0100, 2, 1);
    chk1("scan2dec", 4'b0100, 2, 1);
    tick();
    chk0("scan2dec_hold", 4'b0100, 2, 1);
    chk1("scan2dec_hold", 0, 2, 0);

    enable = 1'b0;
    tick();
    chk0("final_idle", 0, 0, 0);

    inv_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_n_sync.md
DECODER_N_SYNC -- requirements
Module: decoder_n_sync

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- N, 2, select width; legal range 1..6.
- SCAN_DIV, 4, scan-mode dwell in cycles per output; legal range >=1.
- PULSE, 0, decode-mode output style; 0 = level, 1 = single-cycle pulse.

REQ-002 Ports SHALL be, one per line (name direction width meaning):
- clk input 1: the single clock; all state updates on its rising edge.
- rst input 1: reset, synchronous and active-high.
- enable input 1: block enable.
- mode input 1: operating mode; 0 = decode, 1 = scan.
- In input N: select value.
- Output output 2**N: registered one-hot decode.
- index output N: registered binary index of the asserted Output bit.
- valid output 1: registered; high when Output holds a one-hot value.

REQ-003 All outputs SHALL be driven directly from flops, with no combinational path from any input.

Function
REQ-004 The block SHALL implement a 3-state FSM:
- IDLE: enable=0.
- DECODE: enable=1 and mode=0.
- SCAN: enable=1 and mode=1.
The next state SHALL be chosen from enable and mode on every cycle.

REQ-005 enable=0 SHALL take priority over mode: next state IDLE; Output=0, index=0 and valid=0 on the following cycle.

REQ-006 In DECODE with PULSE=0, the block SHALL register Output=1<<In, index=In and valid=1, with 1-cycle latency.

REQ-007 In DECODE with PULSE=1, the block SHALL assert Output=1<<In, index=In and valid=1 for exactly one cycle in these cases:
- the first cycle after entering DECODE;
- the cycle after any change of In.
At all other times Output=0 and valid=0, with index holding its last value.

REQ-008 PULSE=1 change detection SHALL compare In against a registered copy of In. That copy SHALL be captured every cycle, in every state.

REQ-009 On entry to SCAN (from IDLE or DECODE), the block SHALL:
- load the scan index from In;
- clear the dwell counter to 0;
- present Output=1<<In and valid=1 on the next cycle.

REQ-010 While in SCAN, the dwell counter SHALL increment every cycle. When it reaches SCAN_DIV-1 it SHALL:
- return to 0;
- advance the scan index by 1 on the next cycle.
Each index is therefore held for exactly SCAN_DIV cycles.

REQ-011 The scan index SHALL wrap from 2**N-1 to 0 with no idle cycle in between.

REQ-012 With SCAN_DIV=1, the scan index SHALL advance every cycle.

REQ-013 In SCAN, In SHALL be ignored after entry, and PULSE SHALL have no effect.

REQ-014 On SCAN to DECODE, the next-cycle outputs SHALL reflect the DECODE rule (REQ-006/007) for the current In, and the dwell counter SHALL clear.

REQ-015 Leaving SCAN and later re-entering it SHALL restart from In, per REQ-009; scan position SHALL NOT be retained.

REQ-016 Output SHALL always be all-zero or exactly one-hot, and whenever valid=1, Output SHALL equal 1<<index.

REQ-017 The dwell counter SHALL be ceil(log2(SCAN_DIV+1)) bits wide. All index arithmetic SHALL be modulo 2**N.

Reset
REQ-018 While rst=1 at a clock edge, the next cycle SHALL have:
- state=IDLE;
- Output=0, index=0, valid=0;
- dwell counter=0, scan index=0, registered In=0.

REQ-019 rst SHALL override enable and mode, and asserting rst mid-scan SHALL abort the scan within one cycle.

REQ-020 After rst deasserts, the first state transition SHALL occur on the following edge and SHALL be chosen per REQ-004.

Verification (N=2, SCAN_DIV=4 unless stated)
REQ-021 Reset, then enable=1, mode=0, PULSE=0, In sweeps 00,01,10,11, holding each for 10 cycles -> Output=0001,0010,0100,1000 each one cycle after In, valid=1.

REQ-022 PULSE=1, enable=1, mode=0, In=10 held for 5 cycles, then In=11 -> Output=0100 for 1 cycle, then 0000 for 4 cycles, then 1000 for 1 cycle, then 0000.

REQ-023 mode=1, enable=1, In=10 on entry, run 20 cycles -> Output 0100 x4, 1000 x4, 0001 x4, 0010 x4, 0100 x4; index tracks; wrap shows no gap.

REQ-024 Mid-scan at index=11, drop enable -> next cycle Output=0000, valid=0. Re-raise enable with In=01 -> Output=0010 and dwell restarts.

REQ-025 Simultaneous enable 1->0 and mode 0->1 -> IDLE, Output=0000. Also assert rst during SCAN -> next cycle Output=0000, index=00, valid=0.

REQ-026 SCAN_DIV=1, N=3, In=110 -> Output advances one bit per cycle: 01000000, 10000000, 00000001, ...

REQ-027 The bench SHALL check REQ-016 on every cycle of every scenario.
